// File: rtl/seq_multiplier_param.sv
// Parametrised shift-add sequential multiplier, signed/unsigned per operation.
// Optional SEQ_MUL_EARLY_EXIT_EN ends CALC once no multiplier bits remain set.
//
// state  | meaning
// IDLE   | waiting for start, operands captured on start
// CALC   | one multiplier bit retired per cycle
// SIGN   | apply sign to magnitude product, update product
// DONE   | done pulse, then back to IDLE
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier_sh;
  logic                 calc_exit;

  // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is correct as unsigned.
  always_comb begin
    a_mag = multiplier;
    b_mag = multiplicand;
    if (is_signed && multiplier[WIDTH-1])
      a_mag = -multiplier;
    if (is_signed && multiplicand[WIDTH-1])
      b_mag = -multiplicand;
  end

  always_comb begin
    acc_next  = acc;
    if (mplier[0])
      acc_next = acc + mcand;
    mplier_sh = mplier >> 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    calc_exit = (cnt == CW'(1)) || (mplier_sh == '0);
`else
    calc_exit = (cnt == CW'(1));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mplier <= a_mag;
            mcand  <= {{WIDTH{1'b0}}, b_mag};
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            neg    <= is_signed & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            busy   <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_next;
          mplier <= mplier_sh;
          mcand  <= mcand << 1;
          cnt    <= cnt - CW'(1);
          if (calc_exit)
            state <= S_SIGN;
        end
        S_SIGN: begin
          product <= neg ? -acc : acc;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param (WIDTH=8) plus a WIDTH=16 random model check.
// Expected done timing follows SEQ_MUL_EARLY_EXIT_EN when it is defined.
module tb_seq_multiplier_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start8 = 1'b0;
  logic        sgn8 = 1'b0;
  logic [7:0]  mplier8 = '0;
  logic [7:0]  mcand8 = '0;
  logic [15:0] product8;
  logic        busy8;
  logic        done8;

  logic        start16 = 1'b0;
  logic        sgn16 = 1'b0;
  logic [15:0] mplier16 = '0;
  logic [15:0] mcand16 = '0;
  logic [31:0] product16;
  logic        busy16;
  logic        done16;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] prev8 = '0;

  always #5 clk = ~clk;

  seq_multiplier_param #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .multiplier(mplier8), .multiplicand(mcand8),
    .product(product8), .busy(busy8), .done(done8)
  );

  seq_multiplier_param #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .is_signed(sgn16),
    .multiplier(mplier16), .multiplicand(mcand16),
    .product(product16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int e_def, input int e_en);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    return e_en;
`else
    return e_def;
`endif
  endfunction

  // Edge numbering: start sampled at edge 0; observation n is taken just before edge n.
  task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] expp,
                      input int e_def, input int e_en);
    int n;
    logic busy_ok;
    @(negedge clk);
    sgn8 = sgn; mplier8 = a; mcand8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    check({tag, "_hold"}, product8, prev8);
    while (!done8 && n < 40) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy8 !== 1'b1) busy_ok = 1'b0;
    check({tag, "_done_edge"}, n, pick(e_def, e_en));
    check({tag, "_busy_span"}, busy_ok, 1'b1);
    check({tag, "_product"}, product8, expp);
    @(negedge clk);
    check({tag, "_post"}, {busy8, done8}, 2'b00);
    prev8 = expp;
  endtask

  task automatic run16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    int n;
    int hb;
    logic [15:0] mag;
    logic [31:0] expp;
    if (sgn) expp = $signed(a) * $signed(b);
    else     expp = a * b;
    mag = (sgn && a[15]) ? -a : a;
    hb = 0;
    for (int i = 0; i < 16; i++)
      if (mag[i]) hb = i + 1;
    if (hb < 1) hb = 1;
    @(negedge clk);
    sgn16 = sgn; mplier16 = a; mcand16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n = 1;
    while (!done16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("w16_done_edge", n, pick(18, hb + 2));
    check("w16_product", product16, expp);
  endtask

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int dones;

    #12;
    check("reset_state", {product8, busy8, done8}, 18'h0);
    @(negedge clk);
    reset = 1'b1;

    run8("u255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01, 10, 10);
    run8("s_m128xm128",1'b1, 8'h80, 8'h80, 16'h4000, 10, 10);
    run8("s_m3x5",     1'b1, 8'hFD, 8'h05, 16'hFFF1, 10, 4);
    run8("s_5xm3",     1'b1, 8'h05, 8'hFD, 16'hFFF1, 10, 5);
    run8("u_fdx5",     1'b0, 8'hFD, 8'h05, 16'h04F1, 10, 10);
    run8("s_127xm128", 1'b1, 8'h7F, 8'h80, 16'hC080, 10, 9);
    run8("zero_mplier",1'b0, 8'h00, 8'h7F, 16'h0000, 10, 3);
    run8("u_5x7f",     1'b0, 8'h05, 8'h7F, 16'h027B, 10, 5);

    // start pulses with new operands during CALC and during the DONE cycle
    @(negedge clk);
    sgn8 = 1'b0; mplier8 = 8'd9; mcand8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 2) begin start8 = 1'b1; mplier8 = 8'd200; mcand8 = 8'd3; sgn8 = 1'b1; end
      if (i == 3) start8 = 1'b0;
      if (done8) begin
        dones++;
        check("busy_ignore_product", product8, 16'd99);
        start8 = 1'b1; mplier8 = 8'd77; mcand8 = 8'd66;
      end else begin
        if (i != 2) start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("busy_ignore_dones", dones, 1);
    check("busy_ignore_idle", {busy8, product8}, {1'b0, 16'd99});

    // asynchronous reset in the middle of CALC
    sgn8 = 1'b0; mplier8 = 8'd10; mcand8 = 8'd10; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {product8, busy8, done8}, 18'h0);
    @(negedge clk);
    reset = 1'b1;
    prev8 = 16'h0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) n++;
      @(negedge clk);
    end
    check("reset_no_done", n, 0);
    run8("after_reset_6x7", 1'b0, 8'd6, 8'd7, 16'd42, 10, 5);

    for (int i = 0; i < 1000; i++)
      run16(1'($urandom_range(0, 1)), pick_op(), pick_op());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
